// File: rtl/writeback_unit_pkg.sv
// Shared constants for the write-back stage: default width, result-source codes and load funct3 codes.
package writeback_unit_pkg;

    localparam int WORD_SIZE_DEF = 32;

    // Result-source select encodings
    localparam int RES_ALU  = 0;
    localparam int RES_LOAD = 1;
    localparam int RES_PC4  = 2;
    localparam int RES_IMM  = 3;

    // Load size/sign encodings (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// load_extend: combinational lane select and sign/zero extension of a raw memory word.
module load_extend
    import writeback_unit_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    localparam int OFF_W    = $clog2(WORD_SIZE / 8)
) (
    input  logic [WORD_SIZE-1:0] data,
    input  logic [OFF_W-1:0]     offset,
    input  logic [2:0]           funct3,
    output logic [WORD_SIZE-1:0] extended
);

    logic [OFF_W-1:0] offHalf;
    logic [OFF_W-1:0] offWord;
    logic [7:0]       byteLane;
    logic [15:0]      halfLane;
    logic [31:0]      wordLane;

    // Misaligned accesses fall back to the lane at the offset rounded down to the access size.
    always_comb begin
        offHalf  = offset & ~OFF_W'(1);
        offWord  = offset & ~OFF_W'(3);
        byteLane = 8'(data >> {offset, 3'b000});
        halfLane = 16'(data >> {offHalf, 3'b000});
        wordLane = 32'(data >> {offWord, 3'b000});
    end

    // At 32 bits the word lane is the whole datum, so LW/LWU/LD all collapse to a plain copy.
    always_comb begin
        extended = data;
        case (funct3)
            F3_LB:   extended = WORD_SIZE'($signed(byteLane));
            F3_LH:   extended = WORD_SIZE'($signed(halfLane));
            F3_LW:   extended = WORD_SIZE'($signed(wordLane));
            F3_LBU:  extended = WORD_SIZE'(byteLane);
            F3_LHU:  extended = WORD_SIZE'(halfLane);
            F3_LWU:  extended = WORD_SIZE'(wordLane);
            default: extended = data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB register, load extension, result select and register-file write port.
// Optional WB_PERF_EN adds retired_cnt/load_cnt retirement counters.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2,
    localparam int OFF_W     = $clog2(WORD_SIZE / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    output logic                  ready_m,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic [WORD_SIZE-1:0]  alu_result_m,
    input  logic [WORD_SIZE-1:0]  read_data_m,
    input  logic [WORD_SIZE-1:0]  pc_plus4_m,
    input  logic [WORD_SIZE-1:0]  imm_m,
    input  logic [OFF_W-1:0]      addr_lo_m,
    input  logic [2:0]            funct3_m,
    input  logic [SEL_W-1:0]      result_src_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    output logic [WORD_SIZE-1:0]  result_w,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
`ifdef WB_PERF_EN
    output logic [63:0]           retired_cnt,
    output logic [31:0]           load_cnt,
`endif
    output logic                  valid_w
);

    logic [WORD_SIZE-1:0]  aluW;
    logic [WORD_SIZE-1:0]  readDataW;
    logic [WORD_SIZE-1:0]  pcPlus4W;
    logic [WORD_SIZE-1:0]  immW;
    logic [OFF_W-1:0]      addrLoW;
    logic [2:0]            funct3W;
    logic [SEL_W-1:0]      resultSrcW;
    logic                  regWriteW;
    logic [REG_ADDR_W-1:0] rdW;
    logic                  validW;
    logic [WORD_SIZE-1:0]  loadExt;
    logic [WORD_SIZE-1:0]  resultSel;

    // Handshake: the W register takes a new instruction at posedge clk when ready_m (= !stall_w);
    // valid_m then lands in valid_w unless flush_w squashes it. While stalled, everything holds.
    assign ready_m = !stall_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluW       <= '0;
            readDataW  <= '0;
            pcPlus4W   <= '0;
            immW       <= '0;
            addrLoW    <= '0;
            funct3W    <= '0;
            resultSrcW <= '0;
            regWriteW  <= 1'b0;
            rdW        <= '0;
            validW     <= 1'b0;
        end else if (!stall_w) begin
            if (flush_w) begin
                validW <= 1'b0;
            end else begin
                aluW       <= alu_result_m;
                readDataW  <= read_data_m;
                pcPlus4W   <= pc_plus4_m;
                immW       <= imm_m;
                addrLoW    <= addr_lo_m;
                funct3W    <= funct3_m;
                resultSrcW <= result_src_m;
                regWriteW  <= reg_write_m;
                rdW        <= rd_m;
                validW     <= valid_m;
            end
        end
    end

    load_extend #(
        .WORD_SIZE (WORD_SIZE)
    ) u_load_extend (
        .data     (readDataW),
        .offset   (addrLoW),
        .funct3   (funct3W),
        .extended (loadExt)
    );

    // Selects at or beyond NUM_SRC fall back to the ALU result.
    always_comb begin
        resultSel = aluW;
        if (int'(resultSrcW) < NUM_SRC) begin
            case (int'(resultSrcW))
                RES_LOAD: resultSel = loadExt;
                RES_PC4:  resultSel = pcPlus4W;
                RES_IMM:  resultSel = immW;
                default:  resultSel = aluW;
            endcase
        end
    end

    assign result_w = resultSel;
    assign rf_wdata = resultSel;
    assign rf_waddr = rdW;
    assign rf_we    = validW & regWriteW & (rdW != '0);
    assign valid_w  = validW;

`ifdef WB_PERF_EN
    logic retire;
    assign retire = validW & !stall_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            load_cnt    <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 64'd1;
            if (int'(resultSrcW) == RES_LOAD) begin
                load_cnt <= load_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (32-bit default); counter checks compile in with WB_PERF_EN.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        valid_m;
    logic        ready_m;
    logic        stall_w;
    logic        flush_w;
    logic [31:0] alu_result_m;
    logic [31:0] read_data_m;
    logic [31:0] pc_plus4_m;
    logic [31:0] imm_m;
    logic [1:0]  addr_lo_m;
    logic [2:0]  funct3_m;
    logic [1:0]  result_src_m;
    logic        reg_write_m;
    logic [4:0]  rd_m;
    logic [31:0] result_w;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        valid_w;
`ifdef WB_PERF_EN
    logic [63:0] retired_cnt;
    logic [31:0] load_cnt;
`endif

    int checks = 0;
    int errors = 0;

    writeback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_m      (valid_m),
        .ready_m      (ready_m),
        .stall_w      (stall_w),
        .flush_w      (flush_w),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .imm_m        (imm_m),
        .addr_lo_m    (addr_lo_m),
        .funct3_m     (funct3_m),
        .result_src_m (result_src_m),
        .reg_write_m  (reg_write_m),
        .rd_m         (rd_m),
        .result_w     (result_w),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
`ifdef WB_PERF_EN
        .retired_cnt  (retired_cnt),
        .load_cnt     (load_cnt),
`endif
        .valid_w      (valid_w)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [1:0] src,
                         input logic rw, input logic [4:0] rd);
        valid_m      = v;
        alu_result_m = alu;
        result_src_m = src;
        reg_write_m  = rw;
        rd_m         = rd;
    endtask

    task automatic load(input logic [2:0] f3, input logic [1:0] off);
        drive(1'b1, 32'h0, 2'd1, 1'b1, 5'd9);
        read_data_m = 32'h80FF_7F01;
        funct3_m    = f3;
        addr_lo_m   = off;
        step();
    endtask

    initial begin
        rst = 1'b1;
        stall_w = 1'b0;
        flush_w = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
        read_data_m = 32'h0;
        pc_plus4_m  = 32'h0;
        imm_m       = 32'h0;
        addr_lo_m   = 2'd0;
        funct3_m    = 3'b010;
        #3;
        check("reset_valid", 64'(valid_w), 64'd0);
        check("reset_we", 64'(rf_we), 64'd0);
        check("reset_result", 64'(result_w), 64'd0);
        check("reset_waddr", 64'(rf_waddr), 64'd0);
        #4 rst = 1'b0;

        // ALU writeback
        drive(1'b1, 32'h0000_00A5, 2'd0, 1'b1, 5'd7);
        check("ready_idle", 64'(ready_m), 64'd1);
        step();
        check("alu_we", 64'(rf_we), 64'd1);
        check("alu_waddr", 64'(rf_waddr), 64'd7);
        check("alu_wdata", 64'(rf_wdata), 64'h0000_00A5);
        check("alu_valid", 64'(valid_w), 64'd1);

        // Loads from 0x80FF_7F01
        load(3'b000, 2'd3); check("lb_off3", 64'(result_w), 64'hFFFF_FF80);
        load(3'b100, 2'd3); check("lbu_off3", 64'(result_w), 64'h0000_0080);
        load(3'b001, 2'd2); check("lh_off2", 64'(result_w), 64'hFFFF_80FF);
        load(3'b101, 2'd0); check("lhu_off0", 64'(result_w), 64'h0000_7F01);
        load(3'b000, 2'd0); check("lb_off0", 64'(result_w), 64'h0000_0001);
        load(3'b000, 2'd2); check("lb_off2", 64'(result_w), 64'hFFFF_FFFF);
        load(3'b001, 2'd3); check("lh_misalign", 64'(result_w), 64'hFFFF_80FF);
        load(3'b001, 2'd1); check("lh_misalign0", 64'(result_w), 64'h0000_7F01);
        load(3'b010, 2'd1); check("lw_misalign", 64'(result_w), 64'h80FF_7F01);
        load(3'b011, 2'd0); check("ld_at32", 64'(result_w), 64'h80FF_7F01);
        load(3'b110, 2'd0); check("lwu_at32", 64'(result_w), 64'h80FF_7F01);
        load(3'b111, 2'd2); check("f3_111", 64'(result_w), 64'h80FF_7F01);
        check("load_wdata", 64'(rf_wdata), 64'h80FF_7F01);

        // PC+4 and immediate sources
        pc_plus4_m = 32'h0000_0104;
        imm_m      = 32'h1234_5000;
        drive(1'b1, 32'hDEAD_0000, 2'd2, 1'b1, 5'd1);
        step();
        check("pc4_sel", 64'(result_w), 64'h0000_0104);
        drive(1'b1, 32'hDEAD_0000, 2'd3, 1'b1, 5'd31);
        step();
        check("imm_sel", 64'(result_w), 64'h1234_5000);
        check("imm_waddr", 64'(rf_waddr), 64'd31);

        // x0 suppression and reg_write=0
        drive(1'b1, 32'h0000_0055, 2'd0, 1'b1, 5'd0);
        step();
        check("x0_we", 64'(rf_we), 64'd0);
        check("x0_result", 64'(result_w), 64'h0000_0055);
        drive(1'b1, 32'h0000_0066, 2'd0, 1'b0, 5'd5);
        step();
        check("norw_we", 64'(rf_we), 64'd0);

        // Stall holds the W register
        drive(1'b1, 32'h0000_0011, 2'd0, 1'b1, 5'd3);
        step();
        stall_w = 1'b1;
        drive(1'b1, 32'h0000_0022, 2'd2, 1'b1, 5'd4);
        #1;
        check("stall_ready", 64'(ready_m), 64'd0);
        step();
        check("stall_result", 64'(result_w), 64'h0000_0011);
        check("stall_waddr", 64'(rf_waddr), 64'd3);
        check("stall_we", 64'(rf_we), 64'd1);
        step();
        check("stall_hold2", 64'(result_w), 64'h0000_0011);

        // Stall and flush together: stall wins
        flush_w = 1'b1;
        step();
        check("stallflush_valid", 64'(valid_w), 64'd1);
        check("stallflush_waddr", 64'(rf_waddr), 64'd3);

        // Flush alone squashes
        stall_w = 1'b0;
        step();
        check("flush_valid", 64'(valid_w), 64'd0);
        check("flush_we", 64'(rf_we), 64'd0);
        flush_w = 1'b0;

        // Bubble in
        drive(1'b0, 32'h0000_0077, 2'd0, 1'b1, 5'd8);
        step();
        check("bubble_we", 64'(rf_we), 64'd0);

        // Asynchronous reset mid-cycle with a live instruction
        drive(1'b1, 32'h0000_0099, 2'd0, 1'b1, 5'd6);
        step();
        check("pre_rst_we", 64'(rf_we), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid_w), 64'd0);
        check("async_rst_we", 64'(rf_we), 64'd0);
        check("async_rst_result", 64'(result_w), 64'd0);
        #1 rst = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
        step();

`ifdef WB_PERF_EN
        check("cnt_reset", retired_cnt, 64'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i), (i < 4) ? 2'd1 : 2'd0, 1'b1, 5'd2);
            step();
            if (i == 2 || i == 5) begin
                stall_w = 1'b1;
                repeat (3) step();
                stall_w = 1'b0;
            end
        end
        drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
        step();
        step();
        check("retired_cnt", retired_cnt, 64'd10);
        check("load_cnt", 64'(load_cnt), 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
